// File: rtl/serial_bcd_adder.sv
// Digit-serial multi-digit BCD adder: one shared digit slice plus a decimal carry
// register. It processes one digit per clock, least significant digit first, using a start/busy/done handshake.
module serial_bcd_adder #(
    parameter  int DIGITS = 4,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [W-1:0]       op_a_reg;
    logic [W-1:0]       op_b_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               err_pend_reg;

    logic [4:0]         raw_next;
    logic [4:0]         raw_adj_next;
    logic [3:0]         digit_next;
    logic               carry_next;
    logic [W-1:0]       acc_next;
    logic [DIGITS-1:0]  bad_digit;

    // Shared digit slice: binary add, then +6 correction when the sum leaves 0..9.
    always_comb begin
        raw_next     = {1'b0, op_a_reg[3:0]} + {1'b0, op_b_reg[3:0]} + {4'b0000, carry_reg};
        raw_adj_next = raw_next + 5'd6;
        if (raw_next > 5'd9) begin
            digit_next = raw_adj_next[3:0];
            carry_next = 1'b1;
        end else begin
            digit_next = raw_next[3:0];
            carry_next = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign bad_digit[gi] = (a[4*gi +: 4] > 4'd9) | (b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Result digits enter at the top, so after DIGITS shifts digit 0 sits in [3:0].
    generate
        if (DIGITS == 1) begin : g_acc_one
            assign acc_next = digit_next;
        end else begin : g_acc_many
            logic [W-5:0] acc_reg;

            assign acc_next = {digit_next, acc_reg};

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (state_reg == RUN) begin
                    acc_reg <= acc_next[W-1:4];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            err_pend_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            s            <= '0;
            cout         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        op_a_reg     <= a;
                        op_b_reg     <= b;
                        carry_reg    <= cin;
                        err_pend_reg <= |bad_digit;
                        cnt_reg      <= '0;
                        busy         <= 1'b1;
                        state_reg    <= RUN;
                    end else begin
                        state_reg    <= IDLE;
                    end
                end
                RUN: begin
                    op_a_reg  <= op_a_reg >> 4;
                    op_b_reg  <= op_b_reg >> 4;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DIGITS - 1)) begin
                        s         <= acc_next;
                        cout      <= carry_next;
                        err       <= err_pend_reg;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bcd_adder.sv
// Bench for serial_bcd_adder: directed tests on a 4-digit build plus random
// traffic on 1-digit and 8-digit builds, checked against a decimal reference model.
module tb_serial_bcd_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        err;
        logic        chk_s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  cin_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  err_v;
    logic [31:0] a_w [3];
    logic [31:0] b_w [3];
    logic [31:0] s_w [3];
    logic [15:0] s4;
    logic [3:0]  s1;
    logic [31:0] s8;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign s_w[0] = {16'h0000, s4};
    assign s_w[1] = {28'h0000000, s1};
    assign s_w[2] = s8;

    serial_bcd_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_w[0][15:0]), .b(b_w[0][15:0]),
        .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .s(s4), .cout(cout_v[0]), .err(err_v[0])
    );

    serial_bcd_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_w[1][3:0]), .b(b_w[1][3:0]),
        .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .s(s1), .cout(cout_v[1]), .err(err_v[1])
    );

    serial_bcd_adder #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_w[2]), .b(b_w[2]),
        .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .s(s8), .cout(cout_v[2]), .err(err_v[2])
    );

    function automatic int ndig(int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    function automatic longint bcd2int(logic [31:0] v, int d);
        longint r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(longint x, int d);
        logic [31:0] r = '0;
        longint t = x;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic push_exp(int k, exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(int k, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Called at a negedge; returns one negedge after the edge that samples start.
    task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic c,
                         logic [31:0] es, logic ec, logic ee, logic chk);
        exp_t e;
        a_w[k] = a;
        b_w[k] = b;
        cin_v[k] = c;
        start_v[k] = 1'b1;
        e.s = es; e.cout = ec; e.err = ee; e.chk_s = chk;
        push_exp(k, e);
        @(negedge clk);
        start_v[k] = 1'b0;
        a_w[k] = $urandom;
        b_w[k] = $urandom;
        cin_v[k] = 1'($urandom);
    endtask

    // Waits for done, checking busy and output hold on the way, then scores the result.
    task automatic finish_op(int k, int elapsed, string tag);
        int cyc = elapsed;
        logic [31:0] held = s_w[k];
        exp_t e;
        bit ok;
        while (done_v[k] !== 1'b1 && cyc < ndig(k) + 4) begin
            checks++;
            if (s_w[k] !== held || busy_v[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s run_hold: s=%h busy=%b required s=%h busy=1", tag, s_w[k], busy_v[k], held);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: no done after %0d cycles, required done", tag, cyc);
            pop_exp(k, e, ok);
            return;
        end
        checks++;
        if (cyc != ndig(k) || busy_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: done after %0d cycles busy=%b, required %0d cycles busy=0", tag, cyc, busy_v[k], ndig(k));
        end
        pop_exp(k, e, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s scoreboard: done with empty queue, required a pending op", tag);
            return;
        end
        if (e.chk_s && s_w[k] !== e.s) begin
            errors++;
            $display("FAIL %s sum: s=%h required %h", tag, s_w[k], e.s);
        end
        checks++;
        if (cout_v[k] !== e.cout || err_v[k] !== e.err) begin
            errors++;
            $display("FAIL %s flags: cout=%b err=%b required cout=%b err=%b", tag, cout_v[k], err_v[k], e.cout, e.err);
        end
        $display("%s: s=%h cout=%b err=%b latency=%0d", tag, s_w[k], cout_v[k], err_v[k], cyc);
    endtask

    task automatic idle(int k, int n, string tag);
        logic [31:0] held = s_w[k];
        logic hc = cout_v[k];
        logic he = err_v[k];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || s_w[k] !== held || cout_v[k] !== hc || err_v[k] !== he) begin
                errors++;
                $display("FAIL %s idle_hold: done=%b busy=%b s=%h required done=0 busy=0 s=%h", tag, done_v[k], busy_v[k], s_w[k], held);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_v = '0;
        cin_v = '0;
        for (int k = 0; k < 3; k++) begin
            a_w[k] = '0;
            b_w[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || s_w[k] !== 32'h0 || cout_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b s=%h cout=%b err=%b required all zero", k, busy_v[k], done_v[k], s_w[k], cout_v[k], err_v[k]);
            end
        end
        $display("reset: state checked on all builds");
    endtask

    task automatic test_basic();
        issue(0, 32'h1234, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0, 1'b1);
        finish_op(0, 0, "basic_1234_5678");
        idle(0, 2, "basic_pulse");
    endtask

    task automatic test_carry();
        issue(0, 32'h9999, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
        finish_op(0, 0, "carry_9999_0001");
        idle(0, 1, "carry_gap");
        issue(0, 32'h0000, 32'h0000, 1'b1, 32'h0001, 1'b0, 1'b0, 1'b1);
        finish_op(0, 0, "carry_cin_only");
        idle(0, 1, "carry_gap");
        issue(0, 32'h9999, 32'h9999, 1'b1, 32'h9999, 1'b1, 1'b0, 1'b1);
        finish_op(0, 0, "carry_max");
        idle(0, 1, "carry_gap");
    endtask

    task automatic test_err();
        issue(0, 32'h00A0, 32'h0001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        finish_op(0, 0, "err_invalid");
        idle(0, 1, "err_gap");
        issue(0, 32'h0005, 32'h0004, 1'b0, 32'h0009, 1'b0, 1'b0, 1'b1);
        finish_op(0, 0, "err_cleared");
        idle(0, 1, "err_gap");
    endtask

    task automatic test_back_to_back();
        issue(0, 32'h1111, 32'h2222, 1'b0, 32'h3333, 1'b0, 1'b0, 1'b1);
        a_w[0] = 32'h5555;
        b_w[0] = 32'h4444;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        finish_op(0, 1, "ignored_start");
        issue(0, 32'h4321, 32'h1234, 1'b1, 32'h5556, 1'b0, 1'b0, 1'b1);
        finish_op(0, 0, "back_to_back");
        idle(0, 2, "b2b_gap");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit ok;
        issue(0, 32'h1234, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pop_exp(0, e, ok);
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || s_w[0] !== 32'h0 || cout_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b s=%h cout=%b required busy=0 done=0 s=0 cout=0", busy_v[0], done_v[0], s_w[0], cout_v[0]);
        end
        $display("reset_mid: aborted op, busy=%b s=%h", busy_v[0], s_w[0]);
        idle(0, 6, "reset_mid_no_done");
        issue(0, 32'h0458, 32'h0367, 1'b0, 32'h0825, 1'b0, 1'b0, 1'b1);
        finish_op(0, 0, "after_reset");
        idle(0, 1, "after_reset_gap");
    endtask

    task automatic test_random(int k, int n);
        int d = ndig(k);
        longint m = 1;
        for (int i = 0; i < d; i++) m = m * 10;
        for (int t = 0; t < n; t++) begin
            logic [31:0] ra = '0;
            logic [31:0] rb = '0;
            logic rc = 1'($urandom);
            longint sum;
            for (int i = 0; i < d; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            sum = bcd2int(ra, d) + bcd2int(rb, d) + longint'(rc);
            issue(k, ra, rb, rc, int2bcd(sum % m, d), (sum >= m) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            finish_op(k, 0, (k == 1) ? "rand_d1" : "rand_d8");
            if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 3), "rand_gap");
        end
        idle(k, 1, "rand_end");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_random(1, 1000);
        test_random(2, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
